rice_core_div: RTL

RICE_CORE_DIV -- requirements
Module: rice_core_div

---
 rtl/rice_core_pkg.sv | 17 +
 rtl/rice_core_div.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rice_core_pkg.sv
// Shared types for the rice_core divider: one-hot operation select and FSM states.
package rice_core_pkg;

  typedef struct packed {
    logic div;
    logic divu;
    logic rem;
    logic remu;
  } rice_core_div_operation;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } rice_core_div_state_e;

endpackage

// File: rtl/rice_core_div.sv
// Radix-2 restoring divider: one quotient bit per cycle, fixed XLEN+1 cycle latency
// from request to a one-cycle result strobe, with RISC-V div/rem corner-case semantics.
module rice_core_div
  import rice_core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [XLEN-1:0]        i_rs1_value,
  input  logic [XLEN-1:0]        i_rs2_value,
  input  rice_core_div_operation i_div_operation,
  output logic                   o_result_valid,
  output logic [XLEN-1:0]        o_result
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] a);
    return (~a) + XLEN'(1);
  endfunction

  // Returns {next_remainder, quotient_bit}. The shifted partial remainder is XLEN+1 bits;
  // a borrow shows up as bit XLEN set only when the shifted value itself fit in XLEN bits.
  function automatic logic [XLEN:0] restore_step(input logic [XLEN-1:0] rem,
                                                 input logic            dividend_bit,
                                                 input logic [XLEN-1:0] divisor);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;
    shifted = {rem, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    fits    = shifted[XLEN] | ~diff[XLEN];
    return fits ? {diff[XLEN-1:0], 1'b1} : {shifted[XLEN-1:0], 1'b0};
  endfunction

  rice_core_div_state_e r_state, w_state_next;

  logic [CntW-1:0] r_count;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dq;       // dividend bits shift out the top, quotient bits shift in below
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_result;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_want_rem;

  logic            w_signed;
  logic            w_rs1_neg;
  logic            w_rs2_neg;
  logic [XLEN:0]   w_step;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_dq_next;
  logic [XLEN-1:0] w_raw;
  logic            w_raw_neg;
  logic [XLEN-1:0] w_corrected;
  logic            w_last;

  assign w_signed  = i_div_operation.div | i_div_operation.rem;
  assign w_rs1_neg = w_signed & i_rs1_value[XLEN-1];
  assign w_rs2_neg = w_signed & i_rs2_value[XLEN-1];

  assign w_step     = restore_step(r_rem, r_dq[XLEN-1], r_divisor);
  assign w_rem_next = w_step[XLEN:1];
  assign w_dq_next  = {r_dq[XLEN-2:0], w_step[0]};
  assign w_last     = (r_count == CntW'(1));

  // Sign correction runs on the final step's outputs so o_result is a plain register in DONE.
  assign w_raw       = r_want_rem ? w_rem_next : w_dq_next;
  assign w_raw_neg   = r_want_rem ? r_r_neg : r_q_neg;
  assign w_corrected = w_raw_neg ? negate(w_raw) : w_raw;

  always_comb begin
    w_state_next   = r_state;
    o_result_valid = 1'b0;
    unique case (r_state)
      StIdle: if (i_valid) w_state_next = StBusy;
      StBusy: begin
        if (!i_valid) begin
          w_state_next = StIdle;
        end else if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        o_result_valid = i_valid;
        w_state_next   = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_result = o_result_valid ? r_result : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count    <= '0;
      r_rem      <= '0;
      r_dq       <= '0;
      r_divisor  <= '0;
      r_result   <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_want_rem <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_valid) begin
            r_dq       <= w_rs1_neg ? negate(i_rs1_value) : i_rs1_value;
            r_divisor  <= w_rs2_neg ? negate(i_rs2_value) : i_rs2_value;
            // Divide-by-zero keeps the all-ones quotient the datapath produces naturally.
            r_q_neg    <= (w_rs1_neg ^ w_rs2_neg) & (|i_rs2_value);
            r_r_neg    <= w_rs1_neg;
            r_want_rem <= i_div_operation.rem | i_div_operation.remu;
            r_rem      <= '0;
            r_count    <= CntW'(XLEN);
          end
        end
        StBusy: begin
          if (i_valid) begin
            r_rem   <= w_rem_next;
            r_dq    <= w_dq_next;
            r_count <= r_count - CntW'(1);
            if (w_last) r_result <= w_corrected;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
